// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the up/down counter family.
//   COUNTER_DEFAULT_WIDTH - default counter width in bits
//   CNT_DIR_UP/DOWN       - encoding of the up_down control input
package counter_pkg;

   localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

   localparam logic CNT_DIR_UP   = 1'b1;
   localparam logic CNT_DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_nbit_updown_next.sv
// counter_nbit_updown_next: combinational next-value and terminal-count logic.
// Ports:
//   count      in  WIDTH  current counter value
//   enable     in  1      count enable (qualifies tc only)
//   up_down    in  1      direction, CNT_DIR_UP / CNT_DIR_DOWN
//   next_count out WIDTH  value after one step in the selected direction
//   tc         out 1      terminal count: next enabled step would wrap/saturate
// Parameter SAT_EN selects saturate-at-limit instead of modulo wrap.
module counter_nbit_updown_next
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH  = COUNTER_DEFAULT_WIDTH,
   parameter bit          SAT_EN = 1'b0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   input  logic             up_down,
   output logic [WIDTH-1:0] next_count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_MIN = '0;

   logic at_max;
   logic at_min;
   logic dir_up;

   assign at_max = (count == CNT_MAX);
   assign at_min = (count == CNT_MIN);
   assign dir_up = (up_down == CNT_DIR_UP);

   // One step in the selected direction; at a limit either wrap or hold.
   always_comb begin
      next_count = count;
      if (dir_up) begin
         if (!(SAT_EN && at_max)) begin
            next_count = count + WIDTH'(1);
         end
      end else begin
         if (!(SAT_EN && at_min)) begin
            next_count = count - WIDTH'(1);
         end
      end
   end

   // Not gated by load or rst so it can be used to cascade instances.
   assign tc = enable & ((dir_up & at_max) | (!dir_up & at_min));

endmodule : counter_nbit_updown_next

// File: rtl/counter_nbit_updown.sv
// counter_nbit_updown: synchronous WIDTH-bit up/down counter with parallel
// load, count enable and terminal-count flag.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   enable   in  1      count enable
//   data     in  WIDTH  parallel load value
//   load     in  1      synchronous load strobe
//   up_down  in  1      1 = count up, 0 = count down
//   count    out WIDTH  registered counter value
//   tc       out 1      terminal count (combinational from count/enable/up_down)
// Build option: define COUNTER_NBIT_UPDOWN_SAT_EN to saturate at the limits
// instead of wrapping.
module counter_nbit_updown
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

`ifdef COUNTER_NBIT_UPDOWN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [WIDTH-1:0] next_count;

   counter_nbit_updown_next #(
      .WIDTH  (WIDTH),
      .SAT_EN (SAT_EN)
   ) u_next (
      .count      (count),
      .enable     (enable),
      .up_down    (up_down),
      .next_count (next_count),
      .tc         (tc)
   );

   // Priority: rst, load, enable, hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= data;
      end else if (enable) begin
         count <= next_count;
      end
   end

endmodule : counter_nbit_updown

// File: tb/tb_counter_nbit_updown.sv
// tb_counter_nbit_updown: directed self-checking bench for WIDTH=3 and WIDTH=4
// instances sharing one set of control inputs.
module tb_counter_nbit_updown;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] data;
   logic       load;
   logic       up_down;
   logic [2:0] count3;
   logic [3:0] count4;
   logic       tc3;
   logic       tc4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   counter_nbit_updown #(.WIDTH(3)) u_dut3 (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .data    (data[2:0]),
      .load    (load),
      .up_down (up_down),
      .count   (count3),
      .tc      (tc3)
   );

   counter_nbit_updown #(.WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .data    (data),
      .load    (load),
      .up_down (up_down),
      .count   (count4),
      .tc      (tc4)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int up3   [16] = '{1,2,3,4,5,6,7,0,1,2,3,4,5,6,7,0};
   int up4   [16] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0};
   int dn3   [16] = '{7,6,5,4,3,2,1,0,7,6,5,4,3,2,1,0};
   int dn4   [16] = '{15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0};
   int tup3  [16] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0};
   int tup4  [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
   int tdn3  [16] = '{0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,1};
   int tdn4  [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};

   initial begin
      rst = 1'b1; load = 1'b0; enable = 1'b0; up_down = 1'b1; data = 4'd9;

      // Reset, then load zero with enable low.
      #2;
      step();
      check("rst_count3", 8'(count3), 8'd0);
      check("rst_count4", 8'(count4), 8'd0);
      rst = 1'b0; load = 1'b1; data = 4'd0;
      step();
      check("load0_count3", 8'(count3), 8'd0);
      check("load0_count4", 8'(count4), 8'd0);
      check("load0_tc3", 8'(tc3), 8'd0);
      check("load0_tc4", 8'(tc4), 8'd0);

      // Count up 16 edges with wrap.
      load = 1'b0; enable = 1'b1; up_down = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("up_count3[%0d]", i), 8'(count3), 8'(up3[i]));
         check($sformatf("up_count4[%0d]", i), 8'(count4), 8'(up4[i]));
         check($sformatf("up_tc3[%0d]", i), 8'(tc3), 8'(tup3[i]));
         check($sformatf("up_tc4[%0d]", i), 8'(tc4), 8'(tup4[i]));
      end

      // Hold for two edges.
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("hold_count3", 8'(count3), 8'd0);
         check("hold_count4", 8'(count4), 8'd0);
         check("hold_tc3", 8'(tc3), 8'd0);
         check("hold_tc4", 8'(tc4), 8'd0);
      end

      // Count down 16 edges with wrap; tc is up before the first edge at 0.
      up_down = 1'b0; enable = 1'b1;
      #1;
      check("dn_pre_tc3", 8'(tc3), 8'd1);
      check("dn_pre_tc4", 8'(tc4), 8'd1);
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("dn_count3[%0d]", i), 8'(count3), 8'(dn3[i]));
         check($sformatf("dn_count4[%0d]", i), 8'(count4), 8'(dn4[i]));
         check($sformatf("dn_tc3[%0d]", i), 8'(tc3), 8'(tdn3[i]));
         check($sformatf("dn_tc4[%0d]", i), 8'(tc4), 8'(tdn4[i]));
      end

      // Load beats enable; tc is not gated by load (count 0, down, enabled).
      load = 1'b1; data = 4'd5; up_down = 1'b1;
      #1;
      check("ld_pre_tc3", 8'(tc3), 8'd0);
      up_down = 1'b0;
      #1;
      check("ld_pre_tc3_dn", 8'(tc3), 8'd1);
      check("ld_pre_tc4_dn", 8'(tc4), 8'd1);
      up_down = 1'b1;
      step();
      check("prio_load_count3", 8'(count3), 8'd5);
      check("prio_load_count4", 8'(count4), 8'd5);

      // Reset beats load.
      rst = 1'b1; load = 1'b1; data = 4'd5;
      step();
      check("prio_rst_count3", 8'(count3), 8'd0);
      check("prio_rst_count4", 8'(count4), 8'd0);

      // Direction change takes effect on the very next enabled edge.
      rst = 1'b0; load = 1'b1; data = 4'd2;
      step();
      load = 1'b0; up_down = 1'b1;
      step();
      check("dir_up_count3", 8'(count3), 8'd3);
      up_down = 1'b0;
      step();
      check("dir_dn_count3", 8'(count3), 8'd2);
      check("dir_dn_count4", 8'(count4), 8'd2);

`ifdef COUNTER_NBIT_UPDOWN_SAT_EN
      // Saturation: up from 6 sticks at 7 for WIDTH=3.
      load = 1'b1; data = 4'd6;
      step();
      load = 1'b0; up_down = 1'b1; enable = 1'b1;
      step();
      check("sat_up0", 8'(count3), 8'd7);
      check("sat_up0_tc3", 8'(tc3), 8'd1);
      step();
      check("sat_up1", 8'(count3), 8'd7);
      step();
      check("sat_up2", 8'(count3), 8'd7);
      check("sat_up2_count4", 8'(count4), 8'd9);
      // Down from 1 sticks at 0.
      load = 1'b1; data = 4'd1;
      step();
      load = 1'b0; up_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("sat_dn_count3", 8'(count3), 8'd0);
         check("sat_dn_count4", 8'(count4), 8'd0);
         check("sat_dn_tc3", 8'(tc3), 8'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_counter_nbit_updown

// File: doc/counter_nbit_updown.md
Name: counter_nbit_updown

Overview:
- Synchronous, parameterised-width binary up/down counter with parallel load, count enable and a terminal-count flag.
- Generic building block for timers, address generators and sequencers; one clock domain, registered count output.
- Several instances of different WIDTH may share the same control signals.

Parameters:
- WIDTH, default 4, counter width in bits (legal: WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  count enable; counter advances one step per clk edge while high.
- data  input  WIDTH  parallel load value.
- load  input  1  synchronous parallel load strobe.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal count, combinational from count, enable and up_down.

Behaviour:
- All state updates occur on the rising edge of clk. Priority, highest first: rst, load, enable, hold.
- rst = 1: count <= 0 at the next edge, regardless of the other inputs. Reset mid-count aborts the count immediately; a load in the same cycle is ignored.
- load = 1 (rst = 0): count <= data at the next edge. Load is independent of enable; up_down is ignored.
- enable = 1, load = 0, up_down = 1: count <= count + 1 modulo 2^WIDTH. Wraps from 2^WIDTH-1 to 0.
- enable = 1, load = 0, up_down = 0: count <= count - 1 modulo 2^WIDTH. Wraps from 0 to 2^WIDTH-1.
- enable = 0, load = 0: count holds its value.
- up_down may change on any cycle. The new direction takes effect at the next enabled edge, with no dead cycle.
- Latency: one clock from a control change to count; no pipeline beyond the count register.
- tc = enable & ((up_down & count == 2^WIDTH-1) | (~up_down & count == 0)). tc is high in the cycle before a wrap (or a saturate-hold, if the optional feature is enabled). tc is not gated by load or rst.
- Arithmetic is unsigned, WIDTH bits; no carry out beyond tc.
- No X propagation: if data is X on a load the result is don't-care, but control inputs must be known after reset.

Optional Feature:
- Macro COUNTER_NBIT_UPDOWN_SAT_EN.
- When defined, the counter saturates instead of wrapping:
  - up at 2^WIDTH-1 holds at 2^WIDTH-1;
  - down at 0 holds at 0;
  - tc definition is unchanged.
- When undefined, the default modulo-2^WIDTH wrap behaviour above applies.
- Load and reset behaviour are identical in both builds.

Decomposition:
- Shared package counter_pkg holds:
  - localparam COUNTER_DEFAULT_WIDTH = 4;
  - a direction encoding: CNT_DIR_UP = 1'b1, CNT_DIR_DOWN = 1'b0.
- One natural sub-module, counter_nbit_updown_next. It is purely combinational: it takes count, up_down and the saturate option, and produces next_count and tc.
- The top level instantiates counter_nbit_updown_next and contains only the priority mux and the register.

Test Plan:
- Reset and load: rst = 1 for 1 cycle, then load = 1 with data = 0 and enable = 0 for 1 cycle -> count = 0 on both the WIDTH = 3 and WIDTH = 4 instances; tc = 0.
- Count up with wrap: enable = 1, up_down = 1 for 16 edges from 0 -> WIDTH = 3 sequence is 1..7,0,1..7,0 (ends at 0, wrapped twice); WIDTH = 4 sequence is 1..15,0 (ends at 0). tc is high when count = 7 (WIDTH = 3) and when count = 15 (WIDTH = 4).
- Hold: enable = 0 for 2 edges -> count unchanged, tc = 0.
- Count down with wrap: up_down = 0, enable = 1 for 16 edges from 0 -> WIDTH = 3 sequence is 7..0,7..0; WIDTH = 4 sequence is 15..0 (ends at 0). tc is high whenever count = 0 with enable = 1.
- Priority: with enable = 1, assert load with data = 5 -> count = 5 next edge (no increment). Then assert rst and load together -> count = 0.
- Saturation build (COUNTER_NBIT_UPDOWN_SAT_EN, WIDTH = 3): load 6, then count up 3 edges -> 7,7,7. Then count down from 1 for 3 edges -> 0,0,0.
